// File: rtl/conv_output_scheduler.sv
// Serialises rows of kernel results from a 2-entry queue into one feature-map RAM word per cycle.
// Optional build macro CONV_OUT_RELU_EN clamps negative words to zero in the output register.
module conv_output_scheduler #(
    parameter int KERNEL_NUM   = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int TOTAL_WEIGHT = 3,
    parameter int TOTAL_SHIFT  = 6,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic                             result_valid,
    input  logic [KERNEL_NUM*DATA_WIDTH-1:0] result_data,
    input  logic [1:0]                       result_idx,
    input  logic [2:0]                       result_row,
    output logic                             wr_en,
    output logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic signed [DATA_WIDTH-1:0]     wr_data,
    output logic                             busy,
    output logic                             overflow,
    output logic                             image_write_fin
);

    localparam int ROW_W = KERNEL_NUM * DATA_WIDTH;
    localparam int COL_W = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(KERNEL_NUM - 1);
    localparam logic [1:0]       IDX_LAST = 2'(TOTAL_WEIGHT - 1);
    localparam logic [2:0]       ROW_LAST = 3'(TOTAL_SHIFT - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;

    logic [ROW_W-1:0]          fifo_data [2];
    logic [1:0]                fifo_idx  [2];
    logic [2:0]                fifo_row  [2];
    logic                      fifo_last [2];
    logic                      wr_ptr, rd_ptr;
    logic [1:0]                count, cnt_d;

    logic                      push, pop, drop;
    logic                      vld_p0;
    logic signed [DATA_WIDTH-1:0] head_word_p0;
    logic [ADDR_WIDTH-1:0]     addr_p0;
    logic                      last_wr_p1;

    function automatic logic [ADDR_WIDTH-1:0] calc_addr(
        input logic [1:0]       idx,
        input logic [2:0]       row,
        input logic [COL_W-1:0] col
    );
        logic [ADDR_WIDTH-1:0] base;
        base = ADDR_WIDTH'(idx) * ADDR_WIDTH'(TOTAL_SHIFT) + ADDR_WIDTH'(row);
        return base * ADDR_WIDTH'(KERNEL_NUM) + ADDR_WIDTH'(col);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] relu_clamp(
        input logic signed [DATA_WIDTH-1:0] x
    );
`ifdef CONV_OUT_RELU_EN
        return x[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : x;
`else
        return x;
`endif
    endfunction

    // Stage p0: queue bookkeeping, drain FSM and column select
    always_comb begin
        pop  = (state_q == DRAIN) && enable && (col_q == COL_LAST);
        // A pop frees a slot in the same cycle, so a full queue still accepts a row
        push = result_valid && ((count != 2'd2) || pop);
        drop = result_valid && !push;

        case ({push, pop})
            2'b10:   cnt_d = count + 2'd1;
            2'b01:   cnt_d = count - 2'd1;
            default: cnt_d = count;
        endcase

        state_d = state_q;
        col_d   = col_q;
        vld_p0  = 1'b0;
        if (state_q == IDLE) begin
            if (count != 2'd0) begin
                state_d = DRAIN;
                col_d   = '0;
            end
        end else if (enable) begin
            vld_p0 = 1'b1;
            if (pop) begin
                col_d   = '0;
                state_d = (cnt_d != 2'd0) ? DRAIN : IDLE;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        head_word_p0 = '0;
        for (int c = 0; c < KERNEL_NUM; c++) begin
            if (col_q == COL_W'(c)) begin
                head_word_p0 = fifo_data[rd_ptr][c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        addr_p0 = calc_addr(fifo_idx[rd_ptr], fifo_row[rd_ptr], col_q);
    end

    // Queue payload carries no reset; count and pointers decide validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= result_data;
            fifo_idx[wr_ptr]  <= result_idx;
            fifo_row[wr_ptr]  <= result_row;
            fifo_last[wr_ptr] <= (result_idx == IDX_LAST) && (result_row == ROW_LAST);
        end
    end

    // Stage p1: registered write port and status flags
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q         <= IDLE;
            col_q           <= '0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            count           <= 2'd0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            busy            <= 1'b0;
            overflow        <= 1'b0;
            last_wr_p1      <= 1'b0;
            image_write_fin <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            count   <= cnt_d;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (drop) overflow <= 1'b1;

            wr_en <= vld_p0;
            if (vld_p0) begin
                wr_addr <= addr_p0;
                wr_data <= relu_clamp(head_word_p0);
            end
            busy <= (cnt_d != 2'd0) || (state_d == DRAIN) || vld_p0;

            // Completion pulse trails the final word of the image by one cycle
            last_wr_p1      <= pop && fifo_last[rd_ptr];
            image_write_fin <= last_wr_p1;
        end
    end

endmodule

// File: tb/tb_conv_output_scheduler.sv
// Directed, table-driven bench for conv_output_scheduler.
// Honours CONV_OUT_RELU_EN when computing expected write data.
module tb_conv_output_scheduler;

    localparam int KN = 6;
    localparam int DW = 16;
    localparam int AW = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  result_valid;
    logic [KN*DW-1:0]      result_data;
    logic [1:0]            result_idx;
    logic [2:0]            result_row;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic signed [DW-1:0]  wr_data;
    logic                  busy;
    logic                  overflow;
    logic                  image_write_fin;

    conv_output_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .result_idx      (result_idx),
        .result_row      (result_row),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy),
        .overflow        (overflow),
        .image_write_fin (image_write_fin)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                   cyc;
        logic [AW-1:0]        addr;
        logic signed [DW-1:0] data;
    } wr_t;

    wr_t wq[$];
    int  fin_q[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back('{cyc, wr_addr, wr_data});
        if (image_write_fin === 1'b1) fin_q.push_back(cyc);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [DW-1:0] exp_word(input logic signed [DW-1:0] v);
`ifdef CONV_OUT_RELU_EN
        return v[DW-1] ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [KN*DW-1:0] pack6(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5);
        logic [KN*DW-1:0] r;
        int t[KN];
        t = '{a0, a1, a2, a3, a4, a5};
        for (int i = 0; i < KN; i++) r[i*DW +: DW] = 16'(t[i]);
        return r;
    endfunction

    // Column c of a row whose first word lands at base carries (base + c - 20)
    function automatic logic [KN*DW-1:0] build_row(input int base);
        logic [KN*DW-1:0] r;
        for (int i = 0; i < KN; i++) r[i*DW +: DW] = 16'(base + i - 20);
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [1:0] idx, input logic [2:0] row,
                         input logic [KN*DW-1:0] d, output int cap);
        result_valid = 1'b1;
        result_idx   = idx;
        result_row   = row;
        result_data  = d;
        @(posedge clk);
        #1;
        cap          = cyc;
        result_valid = 1'b0;
    endtask

    task automatic check_burst(input string name, input int start_cyc,
                               input int start_addr, input int n);
        int m;
        check({name, "_count"}, wq.size(), n);
        m = (wq.size() < n) ? wq.size() : n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_cyc%0d", name, i), wq[i].cyc, start_cyc + i);
            check($sformatf("%s_addr%0d", name, i), wq[i].addr, start_addr + i);
            check($sformatf("%s_data%0d", name, i), wq[i].data,
                  exp_word(16'(start_addr + i - 20)));
        end
        wq.delete();
    endtask

    typedef struct {
        logic [1:0]       idx;
        logic [2:0]       row;
        logic [KN*DW-1:0] data;
        logic [AW-1:0]    exp_base;
        logic             exp_fin;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cap;
        int dummy;
        int m;
        int fin_at;

        vecs[0] = '{2'd1, 3'd2, pack6(-3, 1, 2, 3, 4, 5),              8'd48,  1'b0};
        vecs[1] = '{2'd0, 3'd0, pack6(100, -1, -32768, 32767, 0, 7),   8'd0,   1'b0};
        vecs[2] = '{2'd2, 3'd4, pack6(-7, 8, -9, 10, -11, 12),         8'd96,  1'b0};
        vecs[3] = '{2'd2, 3'd5, pack6(1, 2, 3, 4, 5, 6),               8'd102, 1'b1};
        vecs[4] = '{2'd3, 3'd7, pack6(-1, -2, 3, 4, -5, 6),            8'd150, 1'b0};

        rst_n        = 1'b1;
        enable       = 1'b1;
        result_valid = 1'b0;
        result_data  = '0;
        result_idx   = 2'd0;
        result_row   = 3'd0;
        step(3);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_fin", image_write_fin, 0);
        rst_n = 1'b0;
        step(2);

        for (int v = 0; v < 5; v++) begin
            wq.delete();
            fin_q.delete();
            pulse(vecs[v].idx, vecs[v].row, vecs[v].data, cap);
            check($sformatf("v%0d_busy_after_capture", v), busy, 1);
            step(7);
            check($sformatf("v%0d_last_wr_en", v), wr_en, 1);
            check($sformatf("v%0d_busy_last_wr", v), busy, 1);
            step(1);
            check($sformatf("v%0d_wr_en_done", v), wr_en, 0);
            check($sformatf("v%0d_busy_done", v), busy, 0);
            check($sformatf("v%0d_fin_now", v), image_write_fin, vecs[v].exp_fin);
            step(2);
            check($sformatf("v%0d_count", v), wq.size(), KN);
            for (int c = 0; c < KN && c < wq.size(); c++) begin
                check($sformatf("v%0d_cyc%0d", v, c), wq[c].cyc, cap + 2 + c);
                check($sformatf("v%0d_addr%0d", v, c), wq[c].addr, vecs[v].exp_base + c);
                check($sformatf("v%0d_data%0d", v, c), wq[c].data,
                      exp_word(vecs[v].data[c*DW +: DW]));
            end
            check($sformatf("v%0d_fin_count", v), fin_q.size(), vecs[v].exp_fin);
            fin_at = (fin_q.size() > 0) ? fin_q[0] : -1;
            check($sformatf("v%0d_fin_cyc", v), fin_at, vecs[v].exp_fin ? cap + 8 : -1);
        end

        // Back-to-back rows six cycles apart drain without a bubble
        wq.delete();
        pulse(2'd0, 3'd0, build_row(0), cap);
        step(5);
        pulse(2'd0, 3'd1, build_row(6), dummy);
        step(14);
        check_burst("b2b", cap + 2, 0, 12);
        check("b2b_overflow", overflow, 0);

        // Third row dropped while writes are paused
        enable = 1'b0;
        wq.delete();
        pulse(2'd0, 3'd1, build_row(6), cap);
        pulse(2'd0, 3'd2, build_row(12), dummy);
        check("ovf_before_third", overflow, 0);
        pulse(2'd0, 3'd3, build_row(18), dummy);
        check("ovf_set", overflow, 1);
        step(4);
        check("ovf_paused_no_writes", wq.size(), 0);
        check("ovf_paused_busy", busy, 1);
        enable = 1'b1;
        m = cyc;
        step(16);
        check_burst("ovf_drain", m + 1, 6, 12);
        check("ovf_sticky", overflow, 1);
        check("ovf_idle_busy", busy, 0);
        rst_n = 1'b1;
        step(1);
        rst_n = 1'b0;
        step(1);
        check("ovf_cleared_by_reset", overflow, 0);

        // Push accepted on the pop cycle of a full queue
        wq.delete();
        pulse(2'd0, 3'd0, build_row(0), cap);
        pulse(2'd0, 3'd1, build_row(6), dummy);
        step(5);
        pulse(2'd0, 3'd2, build_row(12), dummy);
        step(16);
        check_burst("push_on_pop", cap + 2, 0, 18);
        check("push_on_pop_overflow", overflow, 0);

        // Whole image: 18 rows, completion pulse after address 107
        wq.delete();
        fin_q.delete();
        for (int k = 0; k < 18; k++) begin
            pulse(2'(k / 6), 3'(k % 6), build_row(k * 6), dummy);
            if (k == 0) cap = dummy;
            if (k < 17) step(5);
        end
        step(12);
        check_burst("image", cap + 2, 0, 108);
        check("image_fin_count", fin_q.size(), 1);
        fin_at = (fin_q.size() > 0) ? fin_q[0] : -1;
        check("image_fin_cyc", fin_at, cap + 110);
        check("image_overflow", overflow, 0);

        // Reset in the middle of the image's final row
        wq.delete();
        fin_q.delete();
        pulse(2'd2, 3'd5, build_row(102), cap);
        step(4);
        #6;
        rst_n = 1'b1;
        #1;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_writes_before", wq.size(), 3);
        step(1);
        rst_n = 1'b0;
        step(12);
        check("midrst_no_fin", fin_q.size(), 0);
        check("midrst_no_more_writes", wq.size(), 3);
        wq.delete();
        pulse(2'd2, 3'd5, build_row(102), cap);
        step(10);
        check_burst("restart", cap + 2, 102, 6);
        check("restart_fin_count", fin_q.size(), 1);
        fin_at = (fin_q.size() > 0) ? fin_q[0] : -1;
        check("restart_fin_cyc", fin_at, cap + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_output_scheduler.md
# conv_output_scheduler

Sequences finished convolution-kernel results from the conv layer kernel array into the feature-map RAM write port. Each kernel-finish pulse carries one row of KERNEL_NUM parallel results. The block buffers up to two rows in a 2-entry queue and serialises them into one RAM word per cycle with computed addresses. It flags the final write of an image and sits between the conv layer controller/kernel array and the feature buffer.

## Interface
- KERNEL_NUM, 6: results per row (kernel array width).
- DATA_WIDTH, 16: signed result width.
- TOTAL_WEIGHT, 3: feature maps per image.
- TOTAL_SHIFT, 6: rows per feature map.
- ADDR_WIDTH, 8: RAM address width; must satisfy TOTAL_WEIGHT*TOTAL_SHIFT*KERNEL_NUM ≤ 2^ADDR_WIDTH.
- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset: asynchronous and active-high (asserted = 1).
- enable  in  1  drain enable; low pauses RAM writes.
- result_valid  in  1  one-cycle pulse; a row is ready.
- result_data  in  KERNEL_NUM*DATA_WIDTH  row; column c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- result_idx  in  2  feature-map index, sampled with result_valid.
- result_row  in  3  row index, sampled with result_valid.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  (idx*TOTAL_SHIFT + row)*KERNEL_NUM + col.
- wr_data  out  DATA_WIDTH  word written.
- busy  out  1  queue non-empty or drain active.
- overflow  out  1  sticky: a row was dropped.
- image_write_fin  out  1  one-cycle pulse after the last word of (TOTAL_WEIGHT-1, TOTAL_SHIFT-1).

## Operation
- 2-entry FIFO. Each entry holds data, idx, row, and a last flag (idx==TOTAL_WEIGHT-1 && row==TOTAL_SHIFT-1). Pointers wrap modulo 2. Count is 0..2.
- FSM IDLE/DRAIN:
  - IDLE: if count>0, go to DRAIN, load head, col=0.
  - DRAIN: with enable=1, emit column col of the head entry and increment col.
  - At col==KERNEL_NUM-1: pop the entry. If count after pop >0, stay in DRAIN with col=0 (no bubble); else go to IDLE.
  - With enable=0 in DRAIN: wr_en=0; col, state and queue hold.
- Capture: result_valid with count<2 pushes the entry. This holds regardless of enable.
- Full: result_valid with count==2 and no pop that cycle drops the row and sets overflow (cleared only by reset).
- Simultaneous push and pop (last column issued that cycle) is accepted even at count==2; count is unchanged.
- Address arithmetic: unsigned, computed at ADDR_WIDTH. idx>TOTAL_WEIGHT-1 or row>TOTAL_SHIFT-1 is written as computed; no checking is done.
- image_write_fin rises in the cycle after the final wr_en of an entry whose last flag is set.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, overflow=0, image_write_fin=0. FSM=IDLE, queue empty, col=0.
- Outputs are registered.
- Latency from a result_valid edge into an empty queue with enable=1: first wr_en at the edge +2 (capture edge, FSM load edge, then the registered write). The next KERNEL_NUM-1 writes follow on consecutive cycles.
- A row occupies the write port for exactly KERNEL_NUM enabled cycles.
- busy is high from the cycle after capture until the cycle after the final wr_en.
- Reset asserted mid-drain clears the queue, aborts the writes and deasserts wr_en asynchronously. No image_write_fin is issued.

## Configuration
- CONV_OUT_RELU_EN defined: wr_data = result<0 ? 0 : result (signed compare on DATA_WIDTH). The clamp is applied in the output register, with no added latency.
- CONV_OUT_RELU_EN undefined: wr_data passes the stored result unchanged.

## Test plan
- Single row: enable=1, one pulse with idx=1, row=2, columns 0..5 = -3,1,2,3,4,5 -> 6 consecutive wr_en with addr 48..53. Data is 0,1,2,3,4,5 with CONV_OUT_RELU_EN, or -3,1,... without.
- Back-to-back: pulses 6 cycles apart, rows 0 and 1 -> 12 contiguous writes at addr 0..11, no bubble, overflow=0.
- Overflow: three pulses on consecutive cycles with enable=0 -> overflow=1 after the third. Re-enabling yields exactly 12 writes (rows 1, 2).
- Push on pop: queue full, third pulse in the cycle the last column of the head issues -> accepted, 18 writes total, overflow=0.
- Image end: full sequence idx 0..2 × row 0..5 -> 108 writes at addr 0..107, then image_write_fin pulses once, the cycle after addr 107.
- Reset mid-drain: assert rst_n=1 after 3 writes -> wr_en=0 immediately, busy=0. A new pulse after release restarts at col 0.
